// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg
//   Shared constants for the MEM stage: FSM state encoding, memory map
//   defaults and datapath widths. Imported by the MEM-stage files.
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 32;  // data word width
  localparam int REG_W  = 4;   // register index width

  localparam logic [DATA_W-1:0] DEF_BASE_ADDR = 32'd1024;
  localparam int                DEF_DEPTH     = 64;

  // MEM-stage FSM encoding (kept as plain constants for legacy tools)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
//   Data-memory req/ack bus between the MEM-stage controller and memory.
//   master (controller): drives mem_req, mem_we, mem_addr, mem_wdata;
//                        samples mem_rdata, mem_ack.
//   slave  (memory)    : the reverse.
//   mem_ack is a single-cycle strobe; mem_rdata is valid while it is high.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic                                 mem_req;
  logic                                 mem_we;
  logic [ADDR_W-1:0]                    mem_addr;
  logic [mem_stage_ctrl_pkg::DATA_W-1:0] mem_wdata;
  logic [mem_stage_ctrl_pkg::DATA_W-1:0] mem_rdata;
  logic                                 mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl_addr_map.sv
// mem_addr_map
//   Combinational byte-address to word-index translation for data memory.
//   byte_addr : effective byte address from the ALU
//   idx       : word index (byte offset from BASE_ADDR, bits [1:0] dropped)
//   in_range  : BASE_ADDR <= byte_addr < BASE_ADDR + 4*DEPTH
module mem_addr_map
  import mem_stage_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter int                ADDR_W    = 6
) (
  input  logic [DATA_W-1:0] byte_addr,
  output logic [ADDR_W-1:0] idx,
  output logic              in_range
);
  localparam logic [DATA_W-1:0] SPAN = DATA_W'(4 * DEPTH);

  logic [DATA_W-1:0] offset;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned
  // compare covers both ends of the window.
  assign offset   = byte_addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign idx      = offset[ADDR_W+1:2];
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage controller between the EXE/MEM and MEM/WB registers.
//   Turns LDR/STR into word accesses on a req/ack bus, freezing the
//   pipeline while an access is outstanding; other instructions pass
//   through with no stall.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     *_in            : EXE/MEM register outputs (WB_EN, MEM_R_EN, MEM_W_EN,
//                       ALU_Res, Val_Rm, Dest)
//     WB_EN, MEM_R_EN, ALU_Res, Mem_Data, Dest : to MEM/WB register
//     freeze          : stalls upstream registers and PC
//     err             : sticky; out-of-range, R+W both set, or bus timeout
//     bus             : data-memory req/ack bus (master side)
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter int                ADDR_W    = 6,
  parameter int                MAX_WAIT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] ALU_Res_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [REG_W-1:0]  Dest_in,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic [DATA_W-1:0] ALU_Res,
  output logic [DATA_W-1:0] Mem_Data,
  output logic [REG_W-1:0]  Dest,
  output logic              freeze,
  output logic              err,
  mem_stage_ctrl_if.master  bus
);
  localparam int                CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, mem_data_q;

  logic              is_mem;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  mem_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_addr_map (
    .byte_addr (ALU_Res_in),
    .idx       (idx),
    .in_range  (in_range)
  );

  assign is_mem = MEM_R_EN_in | MEM_W_EN_in;

  // Freeze asserts in the same cycle a memory op shows up in IDLE and is
  // released in DONE, so upstream advances exactly once per instruction.
  assign freeze = ((state == S_IDLE) && is_mem) || (state == S_ACCESS);

  // Bubble into MEM/WB while frozen so WB fires only once, in DONE.
  assign WB_EN    = WB_EN_in & ~freeze;
  assign MEM_R_EN = MEM_R_EN_in;
  assign ALU_Res  = ALU_Res_in;
  assign Dest     = Dest_in;
  assign Mem_Data = mem_data_q;
  assign err      = err_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            // R+W together is malformed; it still executes as a store.
            if (MEM_R_EN_in && MEM_W_EN_in) err_q <= 1'b1;
            if (in_range) begin
              req_q    <= 1'b1;
              we_q     <= MEM_W_EN_in;
              addr_q   <= idx;
              wdata_q  <= Val_Rm_in;
              wait_cnt <= '0;
              state    <= S_ACCESS;
            end else begin
              err_q      <= 1'b1;
              mem_data_q <= '0;
              state      <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.mem_ack) begin
            if (!we_q) mem_data_q <= bus.mem_rdata;
            req_q    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            req_q      <= 1'b0;
            mem_data_q <= '0;
            err_q      <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
